// File: rtl/noc_router_q.sv
// Packet router: splits a marked packet stream into per-type FWFT FIFO channels
// and counts packets discarded for a cleared marker bit.
module noc_router_q #(
  parameter int unsigned PAYLOAD_W = 8,
  parameter int unsigned TYPE_W    = 2,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned DEPTH     = 4,
  localparam int unsigned NUM_CH   = 2 ** TYPE_W,
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1,
  localparam int unsigned PKT_W    = 1 + PAYLOAD_W + TYPE_W + ADDR_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PKT_W-1:0]            packet,
  input  logic                        pack_valid,
  output logic                        nocr_ready,
  output logic [NUM_CH-1:0]           ch_valid,
  input  logic [NUM_CH-1:0]           ch_ready,
  output logic [NUM_CH*PAYLOAD_W-1:0] ch_data,
  output logic [NUM_CH*ADDR_W-1:0]    ch_addr,
  output logic [NUM_CH*CNT_W-1:0]     ch_count,
  output logic [7:0]                  drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = PAYLOAD_W + ADDR_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("noc_router_q: DEPTH must be a power of two >= 2");
  end

  logic                 marker;
  logic [PAYLOAD_W-1:0] pkt_payload;
  logic [TYPE_W-1:0]    pkt_type;
  logic [ADDR_W-1:0]    pkt_addr;
  logic [NUM_CH-1:0]    full;
  logic                 accept;

  assign marker      = packet[PKT_W-1];
  assign pkt_payload = packet[ADDR_W+TYPE_W +: PAYLOAD_W];
  assign pkt_type    = packet[ADDR_W +: TYPE_W];
  assign pkt_addr    = packet[ADDR_W-1:0];

  // Full is judged on the pre-edge count, so a same-cycle pop never opens a slot.
  assign nocr_ready = ~marker | ~full[pkt_type];
  assign accept     = pack_valid & nocr_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;

    assign push = accept & marker & (pkt_type == TYPE_W'(i));
    assign pop  = ch_valid[i] & ch_ready[i];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (push && !pop) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end

    // Storage is left unreset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= {pkt_payload, pkt_addr};
    end

    assign head = mem[rd_ptr_q];
    assign full[i]     = (cnt_q == FULL_CNT);
    assign ch_valid[i] = (cnt_q != '0);
    assign ch_data[i*PAYLOAD_W +: PAYLOAD_W] = head[ENT_W-1:ADDR_W];
    assign ch_addr[i*ADDR_W +: ADDR_W]       = head[ADDR_W-1:0];
    assign ch_count[i*CNT_W +: CNT_W]        = cnt_q;
  end

  logic [7:0] drop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
    end else if (accept && !marker && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_noc_router_q.sv
// Directed bench for noc_router_q with a per-channel scoreboard of expected
// {payload, addr} entries pushed on acceptance and popped on DUT handshakes.
module tb_noc_router_q;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] packet;
  logic        pack_valid;
  logic        nocr_ready;
  logic [3:0]  ch_valid;
  logic [3:0]  ch_ready;
  logic [31:0] ch_data;
  logic [7:0]  ch_addr;
  logic [11:0] ch_count;
  logic [7:0]  drop_cnt;

  int tests = 0;
  int fails = 0;
  logic [9:0] sb [NUM_CH][$];
  int drop_m = 0;

  noc_router_q dut (
    .clk        (clk),
    .reset      (reset),
    .packet     (packet),
    .pack_valid (pack_valid),
    .nocr_ready (nocr_ready),
    .ch_valid   (ch_valid),
    .ch_ready   (ch_ready),
    .ch_data    (ch_data),
    .ch_addr    (ch_addr),
    .ch_count   (ch_count),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] mkpkt(logic mk, logic [7:0] pl, logic [1:0] ty, logic [1:0] ad);
    return {mk, pl, ty, ad};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks outputs against the model at the current inputs, then clocks once.
  task automatic step();
    logic [3:0] vexp;
    logic       mk;
    logic [1:0] ty;
    logic       rdy;
    logic [9:0] e;
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      vexp[i] = (sb[i].size() != 0);
      chk($sformatf("ch_count%0d", i), 32'(ch_count[i*3 +: 3]), 32'(sb[i].size()));
    end
    chk("ch_valid", 32'(ch_valid), 32'(vexp));
    chk("drop_cnt", 32'(drop_cnt), 32'(drop_m));
    mk  = packet[12];
    ty  = packet[3:2];
    rdy = !mk || (sb[ty].size() < DEPTH);
    chk("nocr_ready", 32'(nocr_ready), 32'(rdy));
    for (int i = 0; i < NUM_CH; i++) begin
      if (vexp[i] && ch_ready[i]) begin
        e = sb[i].pop_front();
        chk($sformatf("ch%0d_data", i), 32'(ch_data[i*8 +: 8]), 32'(e[9:2]));
        chk($sformatf("ch%0d_addr", i), 32'(ch_addr[i*2 +: 2]), 32'(e[1:0]));
      end
    end
    if (pack_valid && rdy) begin
      if (mk) sb[ty].push_back({packet[11:4], packet[1:0]});
      else if (drop_m != 255) drop_m++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b0;
    packet     = '0;
    pack_valid = 1'b0;
    ch_ready   = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    step();

    // Single packet to channel 1.
    packet = 13'h1A56; pack_valid = 1'b1; step();
    pack_valid = 1'b0;
    #1;
    chk("single_valid", 32'(ch_valid), 32'h2);
    chk("single_data", 32'(ch_data[15:8]), 32'hA5);
    chk("single_addr", 32'(ch_addr[3:2]), 32'h2);
    step();
    ch_ready = 4'b0010; step();
    ch_ready = 4'b0000; step();

    // Overfill channel 0; channel 2 must still accept.
    for (int p = 1; p <= 5; p++) begin
      packet = mkpkt(1'b1, 8'(p), 2'd0, 2'(p)); pack_valid = 1'b1; step();
    end
    chk("ch0_full_count", 32'(ch_count[2:0]), 32'd4);
    packet = mkpkt(1'b1, 8'h77, 2'd0, 2'd1);
    #1;
    chk("full_not_ready", 32'(nocr_ready), 32'd0);
    packet = mkpkt(1'b1, 8'h2C, 2'd2, 2'd3); step();
    // Retry payload 05 while draining; first retry is refused despite the pop.
    packet = mkpkt(1'b1, 8'h05, 2'd0, 2'd1); ch_ready = 4'b0001; step();
    step();
    pack_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    ch_ready = 4'b0100; step();
    ch_ready = 4'b0000; step();

    // Channel 3 held at two entries with simultaneous push/pop across wraps.
    for (int p = 0; p < 2; p++) begin
      packet = mkpkt(1'b1, 8'h30 + 8'(p), 2'd3, 2'(p)); pack_valid = 1'b1; step();
    end
    ch_ready = 4'b1000;
    for (int p = 0; p < 10; p++) begin
      packet = mkpkt(1'b1, 8'h40 + 8'(p), 2'd3, 2'(p + 1)); step();
      chk("ch3_steady_count", 32'(ch_count[11:9]), 32'd2);
    end
    pack_valid = 1'b0;
    step();
    step();
    step();
    ch_ready = 4'b0000;

    // Dropped packets saturate the counter.
    packet = 13'h0A56; pack_valid = 1'b1;
    for (int k = 0; k < 300; k++) step();
    pack_valid = 1'b0;
    #1;
    chk("drop_saturated", 32'(drop_cnt), 32'd255);
    chk("drop_no_valid", 32'(ch_valid), 32'd0);

    // Asynchronous reset with buffered entries.
    for (int p = 0; p < 5; p++) begin
      packet = mkpkt(1'b1, 8'h60 + 8'(p), 2'(p % 2), 2'(p)); pack_valid = 1'b1; step();
    end
    pack_valid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(ch_valid), 32'd0);
    chk("rst_count", 32'(ch_count), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_ready", 32'(nocr_ready), 32'd1);
    for (int i = 0; i < NUM_CH; i++) sb[i].delete();
    drop_m = 0;
    @(negedge clk);
    reset = 1'b1;
    packet = mkpkt(1'b1, 8'h9E, 2'd1, 2'd3); pack_valid = 1'b1; step();
    pack_valid = 1'b0; ch_ready = 4'b0010; step();
    ch_ready = 4'b0000; step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/noc_router_q.md
NOC_ROUTER_Q -- requirements
Module: noc_router_q

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 8, payload width in bits.
REQ-002 SHALL have parameter TYPE_W, default 2, type field width; NUM_CH = 2**TYPE_W output channels.
REQ-003 SHALL have parameter ADDR_W, default 2, address field width.
REQ-004 SHALL have parameter DEPTH, default 4, per-channel FIFO depth; power of two, >= 2; CNT_W = log2(DEPTH)+1.
REQ-005 SHALL define PKT_W = 1+PAYLOAD_W+TYPE_W+ADDR_W (13 at defaults); packet = {marker, payload, type, addr}, addr in the LSBs.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 packet  input  PKT_W  incoming packet.
REQ-009 pack_valid  input  1  packet valid from generator.
REQ-010 nocr_ready  output  1  router can accept packet this cycle.
REQ-011 ch_valid  output  NUM_CH  channel i head entry valid.
REQ-012 ch_ready  input  NUM_CH  consumer i accepts head entry.
REQ-013 ch_data  output  NUM_CH*PAYLOAD_W  channel i head payload in slice i.
REQ-014 ch_addr  output  NUM_CH*ADDR_W  channel i head address in slice i.
REQ-015 ch_count  output  NUM_CH*CNT_W  channel i occupancy, 0..DEPTH.
REQ-016 drop_cnt  output  8  count of discarded packets (marker = 0).

Function
REQ-017 SHALL treat a packet as accepted when pack_valid and nocr_ready are both high on a rising clk edge.
REQ-018 SHALL drive nocr_ready combinationally as (marker == 0) OR (FIFO[type] not full); independent of pack_valid.
REQ-019 SHALL push {payload, addr} into FIFO[type] on acceptance of a packet with marker == 1.
REQ-020 SHALL discard an accepted packet with marker == 0 (no FIFO write) and increment drop_cnt, saturating at 255.
REQ-021 SHALL present FIFO heads first-word-fall-through: ch_valid[i] = (ch_count[i] != 0); ch_data/ch_addr slice i = head entry.
REQ-022 SHALL pop FIFO i when ch_valid[i] and ch_ready[i] are both high on a rising edge.
REQ-023 Latency: packet accepted at edge N SHALL appear on an empty channel with ch_valid high after edge N, i.e. one cycle.
REQ-024 Channels SHALL operate independently; a full channel SHALL NOT block packets destined for other channels.
REQ-025 Order within a channel SHALL be strict FIFO; read/write pointers wrap modulo DEPTH.
REQ-026 Simultaneous push and pop on one channel SHALL leave ch_count unchanged and advance both pointers.
REQ-027 Full channel: nocr_ready SHALL be low for that type even if the same-cycle pop frees a slot; push is retried next cycle.
REQ-028 Pop on empty channel is impossible (ch_valid low); ch_ready while empty SHALL have no effect.
REQ-029 ch_data/ch_addr when ch_valid[i] low are don't-care; verification SHALL NOT check them.

Reset
REQ-030 reset low SHALL immediately clear all pointers, ch_count to 0, ch_valid to 0, drop_cnt to 0; nocr_ready then equals 1.
REQ-031 Reset asserted mid-operation SHALL lose all buffered entries; no pop or push completes at an edge while reset is low.
REQ-032 FIFO storage contents need not be reset.

Verification
REQ-033 Reset pulse low then high, idle -> ch_valid = 0000, all ch_count = 0, drop_cnt = 0, nocr_ready = 1.
REQ-034 Single packet 13'h1A56 (payload A5, type 1, addr 2), ch_ready = 0 -> next cycle ch_valid = 0010, ch1 data A5, addr 2, ch_count[1] = 1.
REQ-035 Five type-0 packets payload 01..05, ch_ready = 0 -> four accepted, nocr_ready low on fifth; type-2 packet still accepted; then ch_ready[0] = 1 drains 01,02,03,04,05 in order.
REQ-036 Channel 3 at count 2, push and pop same cycle -> count stays 2, popped and pushed data order preserved across pointer wrap (10 such pushes).
REQ-037 Packets with marker 0 (e.g. 13'h0A56) x 300 -> no ch_valid change, drop_cnt reaches 255 and holds.
REQ-038 Reset asserted with channels 0 and 1 partially full -> counts 0 and ch_valid 0000 without a clock edge; subsequent packet routes normally.
